// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS freq_word input.
// Accepts one descriptor, then steps the word on a dwell cadence (single, sawtooth or triangle).
module dds_sweep_ctrl #(
    parameter int unsigned FW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_start_fw,
    input  logic [FW-1:0] cfg_step_fw,
    input  logic [CW-1:0] cfg_nsteps,
    input  logic [CW-1:0] cfg_dwell,
    input  logic [1:0]    cfg_mode,
    input  logic          abort,
    output logic [FW-1:0] freq_word,
    output logic          freq_valid,
    output logic [CW-1:0] step_idx,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] MODE_SINGLE   = 2'd0;
    localparam logic [1:0] MODE_SAWTOOTH = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e        state_q,      state_d;
    logic [FW-1:0] start_q,      start_d;
    logic [FW-1:0] step_q,       step_d;
    logic [CW-1:0] nsteps_q,     nsteps_d;
    logic [CW-1:0] dwell_q,      dwell_d;
    logic [1:0]    mode_q,       mode_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          dir_down_q,   dir_down_d;
    logic [FW-1:0] freq_word_q,  freq_word_d;
    logic          freq_valid_q, freq_valid_d;
    logic [CW-1:0] step_idx_q,   step_idx_d;
    logic          busy_q,       busy_d;
    logic          done_q,       done_d;
    logic          cfg_ready_q,  cfg_ready_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_q      <= '0;
            step_q       <= '0;
            nsteps_q     <= '0;
            dwell_q      <= '0;
            mode_q       <= MODE_SINGLE;
            cnt_q        <= '0;
            dir_down_q   <= 1'b0;
            freq_word_q  <= '0;
            freq_valid_q <= 1'b0;
            step_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            step_q       <= step_d;
            nsteps_q     <= nsteps_d;
            dwell_q      <= dwell_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            dir_down_q   <= dir_down_d;
            freq_word_q  <= freq_word_d;
            freq_valid_q <= freq_valid_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        step_d       = step_q;
        nsteps_d     = nsteps_q;
        dwell_d      = dwell_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        dir_down_d   = dir_down_q;
        freq_word_d  = freq_word_q;
        freq_valid_d = 1'b0;
        step_idx_d   = step_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cfg_ready_d  = cfg_ready_q;

        unique case (state_q)
            S_IDLE: begin
                cfg_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (cfg_valid) begin
                    start_d      = cfg_start_fw;
                    step_d       = cfg_step_fw;
                    nsteps_d     = cfg_nsteps;
                    dwell_d      = cfg_dwell;
                    mode_d       = (cfg_mode == 2'd3) ? MODE_SINGLE : cfg_mode;
                    cnt_d        = cfg_dwell;
                    dir_down_d   = 1'b0;
                    freq_word_d  = cfg_start_fw;
                    freq_valid_d = 1'b1;
                    step_idx_d   = '0;
                    busy_d       = 1'b1;
                    cfg_ready_d  = 1'b0;
                    state_d      = S_DWELL;
                end
            end

            S_DWELL: begin
                cfg_ready_d = 1'b0;
                busy_d      = 1'b1;
                if (abort) begin
                    busy_d      = 1'b0;
                    cfg_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = dwell_q;
                    if (step_idx_q < nsteps_q) begin
                        freq_word_d  = dir_down_q ? (freq_word_q - step_q) : (freq_word_q + step_q);
                        step_idx_d   = step_idx_q + CW'(1);
                        freq_valid_d = 1'b1;
                    end else begin
                        // Endpoint of a leg; zero-length repeating sweeps simply park on start
                        unique case (mode_q)
                            MODE_SAWTOOTH: begin
                                if (nsteps_q != '0) begin
                                    freq_word_d  = start_q;
                                    step_idx_d   = '0;
                                    freq_valid_d = 1'b1;
                                end
                            end
                            MODE_TRIANGLE: begin
                                if (nsteps_q != '0) begin
                                    dir_down_d   = ~dir_down_q;
                                    freq_word_d  = dir_down_q ? (freq_word_q + step_q) : (freq_word_q - step_q);
                                    step_idx_d   = CW'(1);
                                    freq_valid_d = 1'b1;
                                end
                            end
                            default: begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        endcase
                    end
                end
            end

            S_DONE: begin
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign cfg_ready  = cfg_ready_q;
    assign freq_word  = freq_word_q;
    assign freq_valid = freq_valid_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps against a
// closed-form per-cycle model of the sweep waveform.
module tb_dds_sweep_ctrl;

    localparam int unsigned FW = 32;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [FW-1:0] cfg_start_fw;
    logic [FW-1:0] cfg_step_fw;
    logic [CW-1:0] cfg_nsteps;
    logic [CW-1:0] cfg_dwell;
    logic [1:0]    cfg_mode;
    logic          abort;
    logic [FW-1:0] freq_word;
    logic          freq_valid;
    logic [CW-1:0] step_idx;
    logic          busy;
    logic          done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    dds_sweep_ctrl #(.FW(FW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_start_fw (cfg_start_fw),
        .cfg_step_fw  (cfg_step_fw),
        .cfg_nsteps   (cfg_nsteps),
        .cfg_dwell    (cfg_dwell),
        .cfg_mode     (cfg_mode),
        .abort        (abort),
        .freq_word    (freq_word),
        .freq_valid   (freq_valid),
        .step_idx     (step_idx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_freq_word"},  freq_word,        32'd0);
        chk({tag, "_freq_valid"}, 32'(freq_valid),  32'd0);
        chk({tag, "_step_idx"},   32'(step_idx),    32'd0);
        chk({tag, "_busy"},       32'(busy),        32'd0);
        chk({tag, "_done"},       32'(done),        32'd0);
        chk({tag, "_cfg_ready"},  32'(cfg_ready),   32'd1);
    endtask

    // One full sweep: accept in cycle 0, then check every cycle k against the model.
    // abort_at = 0 means no abort (only meaningful for single-up mode).
    task automatic run_sweep(input logic [31:0] st, input logic [31:0] sp,
                             input int unsigned ns, input int unsigned dw, input int unsigned md,
                             input int unsigned abort_at, input bit garbage, input bit abort_idle,
                             input bit abort_in_done);
        int unsigned e_md, hold, total, ncyc, w, ph, pos, e_idx, stop;
        logic [31:0] e_fw, held_fw;
        bit e_v, e_busy, e_done, e_rdy;

        e_md    = (md == 3) ? 0 : md;
        hold    = dw + 1;
        total   = (ns + 1) * hold;
        ncyc    = (abort_at > 0) ? abort_at + 2 : total + 3;
        stop    = (abort_at > 0) ? abort_at : total;
        held_fw = st;

        @(negedge clk);
        chk("accept_cfg_ready", 32'(cfg_ready), 32'd1);
        cfg_valid    = 1'b1;
        cfg_start_fw = st;
        cfg_step_fw  = sp;
        cfg_nsteps   = CW'(ns);
        cfg_dwell    = CW'(dw);
        cfg_mode     = 2'(md);
        abort        = abort_idle;

        for (int unsigned k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            w      = (k - 1) / hold;
            ph     = (k - 1) % hold;
            e_idx  = 0;
            e_done = 1'b0;
            if (abort_at > 0 && k > abort_at) begin
                e_fw = held_fw; e_v = 1'b0; e_busy = 1'b0; e_rdy = 1'b1;
            end else if (e_md == 0) begin
                if (k <= total) begin
                    e_fw = st + w * sp; e_idx = w; e_v = (ph == 0); e_busy = 1'b1; e_rdy = 1'b0;
                end else begin
                    e_fw = st + ns * sp; e_v = 1'b0; e_busy = 1'b0;
                    e_done = (k == total + 1);
                    e_rdy  = (k != total + 1);
                end
            end else begin
                e_busy = 1'b1; e_rdy = 1'b0;
                if (ns == 0) begin
                    e_fw = st; e_v = (k == 1);
                end else if (e_md == 1) begin
                    e_idx = w % (ns + 1); e_fw = st + e_idx * sp; e_v = (ph == 0);
                end else begin
                    pos = w % (2 * ns);
                    if (pos > ns) pos = 2 * ns - pos;
                    e_idx = (w == 0) ? 0 : ((w - 1) % ns) + 1;
                    e_fw  = st + pos * sp;
                    e_v   = (ph == 0);
                end
            end
            if (abort_at == 0 || k <= abort_at) held_fw = e_fw;

            chk("freq_word",  freq_word,       e_fw);
            chk("freq_valid", 32'(freq_valid), 32'(e_v));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("done",       32'(done),       32'(e_done));
            chk("cfg_ready",  32'(cfg_ready),  32'(e_rdy));
            if (e_busy) chk("step_idx", 32'(step_idx), e_idx);

            // Next-cycle drive: ignored descriptors while busy, abort requests
            cfg_valid = garbage && (k < stop);
            if (cfg_valid) begin
                cfg_start_fw = $urandom;
                cfg_step_fw  = $urandom;
                cfg_nsteps   = CW'($urandom_range(0, 7));
                cfg_dwell    = CW'($urandom_range(0, 3));
                cfg_mode     = 2'($urandom_range(0, 3));
            end
            abort = (abort_at > 0 && k == abort_at) ||
                    (abort_at == 0 && abort_in_done && k == total + 1);
        end
        cfg_valid = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        logic [31:0] r_st, r_sp;
        int unsigned r_ns, r_dw, r_md, r_ab, r_hold;

        rst_n        = 1'b0;
        cfg_valid    = 1'b0;
        cfg_start_fw = '0;
        cfg_step_fw  = '0;
        cfg_nsteps   = '0;
        cfg_dwell    = '0;
        cfg_mode     = 2'd0;
        abort        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset");

        // Directed cases
        run_sweep(32'h0000_1000, 32'h0000_0100, 3, 1, 0, 0, 1'b0, 1'b0, 1'b0);
        run_sweep(32'hFFFF_FF00, 32'h0000_0100, 1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        run_sweep(32'd0,         32'd10,        2, 0, 2, 9, 1'b0, 1'b0, 1'b0);
        run_sweep(32'd5,         32'd1,         2, 0, 1, 8, 1'b1, 1'b0, 1'b0);
        run_sweep(32'h0000_ABCD, 32'd7,         0, 2, 0, 0, 1'b1, 1'b0, 1'b0);
        run_sweep(32'h0000_ABCD, 32'd7,         0, 2, 2, 10, 1'b0, 1'b0, 1'b0);
        run_sweep(32'h0000_0100, 32'h0000_0200, 2, 1, 3, 0, 1'b0, 1'b1, 1'b0);

        // Async reset mid-dwell, away from any clock edge
        @(negedge clk);
        cfg_valid = 1'b1; cfg_start_fw = 32'h1234_5678; cfg_step_fw = 32'd3;
        cfg_nsteps = CW'(4); cfg_dwell = CW'(5); cfg_mode = 2'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(32'h0000_0040, 32'h0000_0010, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Random descriptors
        for (int r = 0; r < 30; r++) begin
            r_st   = $urandom;
            r_sp   = $urandom;
            r_ns   = $urandom_range(0, 4);
            r_dw   = $urandom_range(0, 3);
            r_md   = $urandom_range(0, 3);
            r_hold = r_dw + 1;
            if (r_md == 1 || r_md == 2)
                r_ab = $urandom_range(1, 3 * (r_ns + 1) * r_hold + 2);
            else if ($urandom_range(0, 1) == 1)
                r_ab = $urandom_range(1, (r_ns + 1) * r_hold);
            else
                r_ab = 0;
            run_sweep(r_st, r_sp, r_ns, r_dw, r_md, r_ab,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
